aer_output_receiver: RTL and testbench
======================================

// Module: aer_output_receiver
// PURPOSE
//  Synthesizable 4-phase AER receiver for the SNN core's output spike bus; replaces bench-side auto-acknowledge.
//  Synchronises REQ, captures the neuron address, acknowledges after a programmable delay, and buffers events in a FIFO.
//  Latches the first spike of each inference (winner digit). Sits between the core AER output and the AXI4-Lite register block.
// PARAMETERS
//  ADDR_W      8   AER address width
//  FIFO_DEPTH  16  event FIFO entries; power of 2, >=2
//  DLY_W       8   width of ACK delay counter
//  N_CLASSES   10  output classes tracked by the histogram (SPIKE_HIST_EN only)
// PORTS
//  CLK          in   1       system clock
//  RST_N        in   1       asynchronous, active-low reset
//  AER_REQ      in   1       AER request; asynchronous to CLK
//  AER_ADDR     in   ADDR_W  AER address; bundled data, stable while AER_REQ=1
//  AER_ACK      out  1       AER acknowledge (registered)
//  CFG_ACK_DLY  in   DLY_W   extra cycles before each ACK edge
//  CLR          in   1       start new inference: flush FIFO, first-spike latch and EVT_CNT
//  EVT_VALID    out  1       FIFO not empty
//  EVT_ADDR     out  ADDR_W  FIFO head address
//  EVT_READY    in   1       pop when EVT_VALID & EVT_READY
//  FIRST_VALID  out  1       first spike since CLR/reset captured
//  FIRST_ADDR   out  ADDR_W  address of that first spike
//  EVT_CNT      out  16      events accepted since CLR/reset; saturates at 16'hFFFF
//  HIST_SEL     in   $clog2(N_CLASSES)  histogram read index (SPIKE_HIST_EN only)
//  HIST_CNT     out  16      spike count of class HIST_SEL (SPIKE_HIST_EN only)
// BEHAVIOUR
//  Reset: AER_ACK=0, EVT_VALID=0, EVT_ADDR=0, FIRST_VALID=0, FIRST_ADDR=0, EVT_CNT=0, HIST_CNT=0; FSM=IDLE; FIFO empty.
//  AER_REQ passes through a 2-FF synchroniser (req_s). AER_ADDR is sampled only when req_s=1.
//  FSM, one transition per CLK:
//   IDLE:    req_s & !full -> CAPTURE; req_s & full -> stay IDLE, ACK held 0 (AER back-pressure)
//   CAPTURE: push AER_ADDR; if !FIRST_VALID latch FIRST_ADDR and set FIRST_VALID; EVT_CNT++; load dly=CFG_ACK_DLY -> DLY_HI
//   DLY_HI:  dly==0 -> ACK_HI (AER_ACK<=1), else dly--
//   ACK_HI:  !req_s -> load dly -> DLY_LO
//   DLY_LO:  dly==0 -> AER_ACK<=0, IDLE; else dly--
//  Latency: req_s high at edge k -> push at edge k+1; EVT_VALID=1 after k+1; AER_ACK=1 after edge k+2+CFG_ACK_DLY.
//  CFG_ACK_DLY is sampled at each delay load; changes mid-delay do not affect the running count.
//  FIFO: push/pop on the same cycle allowed, count unchanged; pop when empty ignored; pointers wrap modulo FIFO_DEPTH;
//   full is registered; IDLE never enters CAPTURE when full, so no event is ever dropped.
//  CLR (1 cycle, synchronous): empties FIFO, clears FIRST_VALID/FIRST_ADDR/EVT_CNT/histogram next edge.
//   A push coinciding with CLR is discarded: CLR wins. The FSM is NOT reset, so an in-flight handshake completes normally.
//  RST_N low mid-handshake: AER_ACK drops immediately (async); the sender must re-issue its request.
// CONFIGURATION
//  SPIKE_HIST_EN defined: N_CLASSES x 16-bit saturating counters, incremented in CAPTURE when addr<N_CLASSES,
//   cleared by CLR; HIST_CNT = cnt[HIST_SEL] (registered, 1-cycle latency); HIST_SEL>=N_CLASSES returns 0.
//  SPIKE_HIST_EN undefined: no counters, HIST_SEL ignored, HIST_CNT tied 0.
// STRUCTURE
//  pa_SnnAccelerator: AER_ADDR_WIDTH and AER_FIFO_DEPTH constants; typedef enum {IDLE,CAPTURE,DLY_HI,ACK_HI,DLY_LO} aer_rx_state_t.
//  Sub-module aer_evt_fifo (ADDR_W, FIFO_DEPTH): sync FIFO with flush input.
//  Synchroniser, FSM, first-spike latch and histogram are inline.
// TESTING
//  1) CFG_ACK_DLY=0; send addr 8'h07 -> ACK rises 2 CLK after req_s; EVT_ADDR=7; FIRST_ADDR=7; EVT_CNT=1.
//  2) CFG_ACK_DLY=5; send addr 3 -> ACK rises 7 CLK after req_s and falls 6 CLK after req_s drops.
//  3) EVT_READY=0; send 17 events with FIFO_DEPTH=16 -> 16 ACKed, 17th REQ unacked until one pop,
//     then its addr is in the FIFO; pop order matches send order.
//  4) Send 4,9,4; CLR; send 2 -> FIRST_ADDR=2, EVT_CNT=1, FIFO holds only 2.
//  5) CLR asserted in the CAPTURE cycle of addr 5 -> FIFO empty, FIRST_VALID=0; handshake still completes.
//  6) SPIKE_HIST_EN: send 3,3,12,3 with N_CLASSES=10 -> HIST_SEL=3 gives 3; HIST_SEL=12 gives 0; EVT_CNT=4.

Source files
------------

// File: rtl/pa_SnnAccelerator.sv
// Shared constants and receive-FSM state type for the SNN accelerator AER output path.
package pa_SnnAccelerator;

  localparam int AER_ADDR_WIDTH = 8;
  localparam int AER_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DLY_HI,
    ACK_HI,
    DLY_LO
  } aer_rx_state_t;

endpackage

// File: rtl/aer_evt_fifo.sv
// Synchronous spike-event FIFO: registered full flag, synchronous flush that beats a coincident push or pop.
module aer_evt_fifo #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q;
  logic              push_ok, pop_ok;

  assign push_ok = push_i && !full_q && !flush_i;
  assign pop_ok  = pop_i && (count_q != '0) && !flush_i;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers are PTR_W wide, so wrap modulo FIFO_DEPTH comes for free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == (PTR_W+1)'(FIFO_DEPTH));
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/aer_output_receiver.sv
// 4-phase AER receiver for the SNN core output bus: REQ sync, delayed ACK, event FIFO, first-spike latch.
// Optional per-class spike histogram is built when SPIKE_HIST_EN is defined.
module aer_output_receiver
  import pa_SnnAccelerator::*;
#(
  parameter int ADDR_W     = AER_ADDR_WIDTH,
  parameter int FIFO_DEPTH = AER_FIFO_DEPTH,
  parameter int DLY_W      = 8,
  parameter int N_CLASSES  = 10
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         AER_REQ,
  input  logic [ADDR_W-1:0]            AER_ADDR,
  output logic                         AER_ACK,
  input  logic [DLY_W-1:0]             CFG_ACK_DLY,
  input  logic                         CLR,
  output logic                         EVT_VALID,
  output logic [ADDR_W-1:0]            EVT_ADDR,
  input  logic                         EVT_READY,
  output logic                         FIRST_VALID,
  output logic [ADDR_W-1:0]            FIRST_ADDR,
  output logic [15:0]                  EVT_CNT,
  input  logic [$clog2(N_CLASSES)-1:0] HIST_SEL,
  output logic [15:0]                  HIST_CNT,
  output aer_rx_state_t                DBG_STATE
);

  logic              req_meta_q, req_s_q;
  aer_rx_state_t     state_q;
  logic [DLY_W-1:0]  dly_q;
  logic              ack_q;
  logic              push;
  logic              fifo_empty, fifo_full;
  logic              first_valid_q;
  logic [ADDR_W-1:0] first_addr_q;
  logic [15:0]       evt_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= AER_REQ;
      req_s_q    <= req_meta_q;
    end
  end

  // Holding IDLE while the FIFO is full withholds ACK, which back-pressures the sender.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      dly_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s_q && !fifo_full) state_q <= CAPTURE;
        end
        CAPTURE: begin
          dly_q   <= CFG_ACK_DLY;
          state_q <= DLY_HI;
        end
        DLY_HI: begin
          if (dly_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= ACK_HI;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        ACK_HI: begin
          if (!req_s_q) begin
            dly_q   <= CFG_ACK_DLY;
            state_q <= DLY_LO;
          end
        end
        DLY_LO: begin
          if (dly_q == '0) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push      = (state_q == CAPTURE);
  assign AER_ACK   = ack_q;
  assign DBG_STATE = state_q;

  // Event stream: a beat transfers on a cycle where EVT_VALID and EVT_READY are both high;
  // EVT_VALID/EVT_ADDR hold until that transfer, and EVT_READY may be driven freely.
  aer_evt_fifo #(
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .flush_i(CLR),
    .push_i (push),
    .data_i (AER_ADDR),
    .pop_i  (EVT_READY),
    .data_o (EVT_ADDR),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign EVT_VALID = !fifo_empty;

  // CLR wins over a coincident capture so nothing from the old inference leaks through.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_valid_q <= 1'b0;
      first_addr_q  <= '0;
      evt_cnt_q     <= '0;
    end else if (CLR) begin
      first_valid_q <= 1'b0;
      first_addr_q  <= '0;
      evt_cnt_q     <= '0;
    end else if (push) begin
      if (!first_valid_q) begin
        first_valid_q <= 1'b1;
        first_addr_q  <= AER_ADDR;
      end
      if (evt_cnt_q != 16'hFFFF) evt_cnt_q <= evt_cnt_q + 16'd1;
    end
  end

  assign FIRST_VALID = first_valid_q;
  assign FIRST_ADDR  = first_addr_q;
  assign EVT_CNT     = evt_cnt_q;

`ifdef SPIKE_HIST_EN
  logic [15:0] hist_q [N_CLASSES];
  logic [15:0] hist_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_CLASSES; i++) hist_q[i] <= '0;
      hist_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_CLASSES; i++) begin
        if (CLR) begin
          hist_q[i] <= '0;
        end else if (push && (32'(AER_ADDR) == i) && (hist_q[i] != 16'hFFFF)) begin
          hist_q[i] <= hist_q[i] + 16'd1;
        end
      end
      hist_cnt_q <= (32'(HIST_SEL) < N_CLASSES) ? hist_q[HIST_SEL] : '0;
    end
  end

  assign HIST_CNT = hist_cnt_q;
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^HIST_SEL;
  assign HIST_CNT        = '0;
`endif

endmodule

// File: tb/tb_aer_output_receiver.sv
// Bench for aer_output_receiver: 4-phase AER sender model, FIFO scoreboard, ACK timing, CLR and back-pressure.
module tb_aer_output_receiver;
  import pa_SnnAccelerator::*;

`ifdef SPIKE_HIST_EN
  localparam bit HIST_ON = 1'b1;
`else
  localparam bit HIST_ON = 1'b0;
`endif

  logic          clk, rst_n, aer_req, aer_ack, clr;
  logic          evt_valid, evt_ready, first_valid;
  logic [7:0]    aer_addr, evt_addr, first_addr, cfg_ack_dly;
  logic [15:0]   evt_cnt, hist_cnt;
  logic [3:0]    hist_sel;
  aer_rx_state_t dbg_state;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  aer_output_receiver #(
    .ADDR_W(8), .FIFO_DEPTH(16), .DLY_W(8), .N_CLASSES(10)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .AER_REQ(aer_req), .AER_ADDR(aer_addr), .AER_ACK(aer_ack),
    .CFG_ACK_DLY(cfg_ack_dly), .CLR(clr), .EVT_VALID(evt_valid), .EVT_ADDR(evt_addr),
    .EVT_READY(evt_ready), .FIRST_VALID(first_valid), .FIRST_ADDR(first_addr),
    .EVT_CNT(evt_cnt), .HIST_SEL(hist_sel), .HIST_CNT(hist_cnt), .DBG_STATE(dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Driver tasks (all start and end on a negedge)
  task automatic aer_raise(input logic [7:0] addr);
    aer_addr = addr;
    aer_req  = 1'b1;
  endtask

  task automatic aer_drop();
    aer_req = 1'b0;
  endtask

  // edges = number of posedges until AER_ACK reaches level, -1 if the budget expired
  task automatic wait_ack(input logic level, input int budget, output int edges);
    edges = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (aer_ack === level) begin
        edges = n;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic aer_send(input logic [7:0] addr, output int rise, output int fall);
    aer_raise(addr);
    wait_ack(1'b1, 60, rise);
    aer_drop();
    wait_ack(1'b0, 60, fall);
  endtask

  task automatic pop_evt(output logic [7:0] addr, output logic valid);
    valid = evt_valid;
    addr  = evt_addr;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    evt_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; aer_req = 1'b0; aer_addr = '0; cfg_ack_dly = '0;
    clr = 1'b0; evt_ready = 1'b0; hist_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({aer_ack, evt_valid, first_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got ack/valid/first=%b expected 000", {aer_ack, evt_valid, first_valid});
    end
    checks++;
    if ({evt_addr, first_addr} !== 16'h0000) begin
      errors++; $display("FAIL reset_addrs: got evt=%0h first=%0h expected 0/0", evt_addr, first_addr);
    end
    checks++;
    if ({evt_cnt, hist_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_counts: got evt_cnt=%0d hist_cnt=%0d expected 0/0", evt_cnt, hist_cnt);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_event();
    int rise, fall; logic [7:0] got, want; logic vld;
    cfg_ack_dly = 8'd0;
    aer_raise(8'h07); exp_q.push_back(8'h07);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL valid_before_push: got %0b expected 0", evt_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (evt_valid !== 1'b1 || evt_addr !== 8'h07) begin
      errors++; $display("FAIL valid_after_push: got valid=%0b addr=%0h expected 1/07", evt_valid, evt_addr);
    end
    @(negedge clk);
    wait_ack(1'b1, 20, rise);
    checks++;
    if (rise !== 1) begin
      errors++; $display("FAIL ack_rise_dly0: got edge %0d after push expected 1", rise);
    end
    checks++;
    if (first_valid !== 1'b1 || first_addr !== 8'h07 || evt_cnt !== 16'd1) begin
      errors++; $display("FAIL first_single: got fv=%0b fa=%0h cnt=%0d expected 1/07/1", first_valid, first_addr, evt_cnt);
    end
    aer_drop();
    wait_ack(1'b0, 20, fall);
    checks++;
    if (fall !== 4) begin
      errors++; $display("FAIL ack_fall_dly0: got %0d edges expected 4", fall);
    end
    while (exp_q.size() > 0) begin
      pop_evt(got, vld); want = exp_q.pop_front(); checks++;
      if (!vld || got !== want) begin
        errors++; $display("FAIL single_pop: got valid=%0b addr=%0h expected addr=%0h", vld, got, want);
      end
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL single_empty: got valid=%0b expected 0", evt_valid);
    end
  endtask

  task automatic test_ack_delay();
    int rise, fall; logic [7:0] got, want; logic vld;
    cfg_ack_dly = 8'd5;
    aer_raise(8'h03); exp_q.push_back(8'h03);
    wait_ack(1'b1, 40, rise);
    checks++;
    if (rise !== 10) begin
      errors++; $display("FAIL ack_rise_dly5: got %0d edges from REQ expected 10", rise);
    end
    aer_drop();
    wait_ack(1'b0, 40, fall);
    checks++;
    if (fall !== 9) begin
      errors++; $display("FAIL ack_fall_dly5: got %0d edges from REQ drop expected 9", fall);
    end
    // Changing the delay mid-count must not disturb the running count.
    cfg_ack_dly = 8'd2;
    aer_raise(8'h5A); exp_q.push_back(8'h5A);
    repeat (5) @(posedge clk);
    @(negedge clk);
    cfg_ack_dly = 8'd9;
    wait_ack(1'b1, 40, rise);
    checks++;
    if (rise !== 2) begin
      errors++; $display("FAIL ack_dly_midchange: got %0d further edges expected 2", rise);
    end
    aer_drop();
    wait_ack(1'b0, 40, fall);
    checks++;
    if (fall !== 13) begin
      errors++; $display("FAIL ack_fall_dly9: got %0d edges expected 13", fall);
    end
    cfg_ack_dly = 8'd0;
    while (exp_q.size() > 0) begin
      pop_evt(got, vld); want = exp_q.pop_front(); checks++;
      if (!vld || got !== want) begin
        errors++; $display("FAIL delay_pop: got valid=%0b addr=%0h expected addr=%0h", vld, got, want);
      end
    end
  endtask

  task automatic test_back_pressure();
    int rise, fall, acked; logic [7:0] a, got, want; logic vld;
    cfg_ack_dly = 8'd0; evt_ready = 1'b0;
    clr_pulse();
    acked = 0;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom_range(0, 255));
      exp_q.push_back(a);
      aer_send(a, rise, fall);
      if (rise > 0 && fall > 0) acked++;
    end
    checks++;
    if (acked !== 16) begin
      errors++; $display("FAIL bp_fill_acked: got %0d handshakes expected 16", acked);
    end
    a = 8'($urandom_range(0, 255));
    aer_raise(a); exp_q.push_back(a);
    wait_ack(1'b1, 30, rise);
    checks++;
    if (rise !== -1 || aer_ack !== 1'b0) begin
      errors++; $display("FAIL bp_no_ack_full: got rise=%0d ack=%0b expected -1/0", rise, aer_ack);
    end
    checks++;
    if (dbg_state !== IDLE || evt_cnt !== 16'd16) begin
      errors++; $display("FAIL bp_stall: got state=%0d cnt=%0d expected %0d/16", dbg_state, evt_cnt, IDLE);
    end
    pop_evt(got, vld); want = exp_q.pop_front(); checks++;
    if (!vld || got !== want) begin
      errors++; $display("FAIL bp_first_pop: got valid=%0b addr=%0h expected addr=%0h", vld, got, want);
    end
    wait_ack(1'b1, 20, rise);
    checks++;
    if (rise !== 3) begin
      errors++; $display("FAIL bp_ack_after_pop: got %0d edges expected 3", rise);
    end
    aer_drop();
    wait_ack(1'b0, 20, fall);
    checks++;
    if (fall !== 4 || evt_cnt !== 16'd17) begin
      errors++; $display("FAIL bp_release: got fall=%0d cnt=%0d expected 4/17", fall, evt_cnt);
    end
    while (exp_q.size() > 0) begin
      pop_evt(got, vld); want = exp_q.pop_front(); checks++;
      if (!vld || got !== want) begin
        errors++; $display("FAIL bp_order: got valid=%0b addr=%0h expected addr=%0h", vld, got, want);
      end
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got valid=%0b expected 0", evt_valid);
    end
  endtask

  task automatic test_clr_new_inference();
    int rise, fall; logic [7:0] got, want; logic vld;
    logic [7:0] seq [3];
    seq = '{8'd4, 8'd9, 8'd4};
    clr_pulse();
    foreach (seq[i]) aer_send(seq[i], rise, fall);
    checks++;
    if (first_valid !== 1'b1 || first_addr !== 8'd4 || evt_cnt !== 16'd3) begin
      errors++; $display("FAIL clr_pre: got fv=%0b fa=%0h cnt=%0d expected 1/04/3", first_valid, first_addr, evt_cnt);
    end
    clr_pulse();
    checks++;
    if ({evt_valid, first_valid} !== 2'b00 || first_addr !== 8'd0 || evt_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_flush: got v=%0b fv=%0b fa=%0h cnt=%0d expected 0/0/00/0",
                         evt_valid, first_valid, first_addr, evt_cnt);
    end
    exp_q.push_back(8'd2);
    aer_send(8'd2, rise, fall);
    checks++;
    if (first_valid !== 1'b1 || first_addr !== 8'd2 || evt_cnt !== 16'd1) begin
      errors++; $display("FAIL clr_post: got fv=%0b fa=%0h cnt=%0d expected 1/02/1", first_valid, first_addr, evt_cnt);
    end
    while (exp_q.size() > 0) begin
      pop_evt(got, vld); want = exp_q.pop_front(); checks++;
      if (!vld || got !== want) begin
        errors++; $display("FAIL clr_fifo: got valid=%0b addr=%0h expected addr=%0h", vld, got, want);
      end
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL clr_only_one: got valid=%0b expected 0", evt_valid);
    end
  endtask

  task automatic test_clr_in_capture();
    int rise, fall;
    cfg_ack_dly = 8'd0;
    clr_pulse();
    aer_raise(8'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state !== CAPTURE) begin
      errors++; $display("FAIL cap_state: got %0d expected %0d", dbg_state, CAPTURE);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (evt_valid !== 1'b0 || first_valid !== 1'b0 || evt_cnt !== 16'd0) begin
      errors++; $display("FAIL cap_clr_wins: got v=%0b fv=%0b cnt=%0d expected 0/0/0", evt_valid, first_valid, evt_cnt);
    end
    @(negedge clk);
    wait_ack(1'b1, 20, rise);
    aer_drop();
    wait_ack(1'b0, 20, fall);
    checks++;
    if (rise !== 1 || fall !== 4 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL cap_handshake: got rise=%0d fall=%0d v=%0b expected 1/4/0", rise, fall, evt_valid);
    end
  endtask

  task automatic test_histogram();
    int rise, fall; logic [7:0] got, want; logic vld;
    logic [7:0] seq [4];
    seq = '{8'd3, 8'd3, 8'd12, 8'd3};
    clr_pulse();
    foreach (seq[i]) begin
      exp_q.push_back(seq[i]);
      aer_send(seq[i], rise, fall);
    end
    hist_sel = 4'd3;
    @(posedge clk); #1;
    checks++;
    if (hist_cnt !== (HIST_ON ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL hist_class3: got %0d expected %0d", hist_cnt, HIST_ON ? 3 : 0);
    end
    @(negedge clk);
    hist_sel = 4'd12;
    @(posedge clk); #1;
    checks++;
    if (hist_cnt !== 16'd0 || evt_cnt !== 16'd4) begin
      errors++; $display("FAIL hist_out_of_range: got hist=%0d cnt=%0d expected 0/4", hist_cnt, evt_cnt);
    end
    @(negedge clk);
    hist_sel = 4'd3;
    clr_pulse();
    @(posedge clk); #1;
    checks++;
    if (hist_cnt !== 16'd0) begin
      errors++; $display("FAIL hist_cleared: got %0d expected 0", hist_cnt);
    end
    @(negedge clk);
    exp_q.delete();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL hist_flush: got valid=%0b expected 0", evt_valid);
    end
    exp_q.push_back(8'd3);
    aer_send(8'd3, rise, fall);
    while (exp_q.size() > 0) begin
      pop_evt(got, vld); want = exp_q.pop_front(); checks++;
      if (!vld || got !== want) begin
        errors++; $display("FAIL hist_pop: got valid=%0b addr=%0h expected addr=%0h", vld, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    int rise, fall; logic [7:0] got, want; logic vld;
    cfg_ack_dly = 8'd0;
    aer_raise(8'h21);
    wait_ack(1'b1, 20, rise);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (aer_ack !== 1'b0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL async_rst_ack: got ack=%0b state=%0d expected 0/%0d", aer_ack, dbg_state, IDLE);
    end
    aer_drop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (evt_valid !== 1'b0 || evt_cnt !== 16'd0) begin
      errors++; $display("FAIL async_rst_state: got v=%0b cnt=%0d expected 0/0", evt_valid, evt_cnt);
    end
    exp_q.push_back(8'h21);
    aer_send(8'h21, rise, fall);
    checks++;
    if (rise !== 5 || fall !== 4) begin
      errors++; $display("FAIL async_rst_reissue: got rise=%0d fall=%0d expected 5/4", rise, fall);
    end
    while (exp_q.size() > 0) begin
      pop_evt(got, vld); want = exp_q.pop_front(); checks++;
      if (!vld || got !== want) begin
        errors++; $display("FAIL async_rst_pop: got valid=%0b addr=%0h expected addr=%0h", vld, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_ack_delay();
    test_back_pressure();
    test_clr_new_inference();
    test_clr_in_capture();
    test_histogram();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
